// File: rtl/key_click_decoder.sv
// key_click_decoder
// Turns debounced press pulses and key level into single click, double click
// and long press events. One decoder handles one key.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no gesture in progress, waiting for a press pulse
// PRESS1    | first press held, timing toward a long press
// WAIT2     | released after first press, timing the double-click window
// PRESS2    | second press held, waiting for release (no long detection)
// LONG_HELD | long press already reported, waiting for release
module key_click_decoder #(
  parameter int DBL_WIN  = 3000000,
  parameter int LONG_CNT = 12000000,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pulse,
  input  logic key_level,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_t;

  // Terminal counts: a timer that was cleared on entry reaches these on the
  // DBL_WIN-th / LONG_CNT-th edge after entry.
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_WIN - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Gesture FSM with registered event pulses, busy flag and shared timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Event pulses last one cycle unless re-asserted below.
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;

      case (state)
        ST_IDLE: begin
          // key_level deliberately ignored here; only a press pulse starts a gesture.
          if (key_pulse) begin
            state <= ST_PRESS1;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        ST_PRESS1: begin
          // Release wins over long-press expiry in the same cycle.
          if (key_level) begin
            state <= ST_WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= ST_LONG_HELD;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          busy <= 1'b1;
        end

        ST_WAIT2: begin
          // A second press on the expiry edge still counts as a double click.
          if (key_pulse) begin
            state        <= ST_PRESS2;
            cnt          <= '0;
            double_click <= 1'b1;
            busy         <= 1'b1;
          end else if (cnt == DBL_LAST) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            single_click <= 1'b1;
            busy         <= 1'b0;
          end else begin
            cnt  <= cnt + 1'b1;
            busy <= 1'b1;
          end
        end

        ST_PRESS2: begin
          // Further press pulses are part of this gesture, not a new one.
          if (key_level) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            busy  <= 1'b1;
          end
        end

        ST_LONG_HELD: begin
          if (key_level) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            busy  <= 1'b1;
          end
        end

        default: begin
          // Unused encodings fall back to IDLE.
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder
// Directed bench for key_click_decoder with DBL_WIN=8, LONG_CNT=20.
// Edge numbers are relative to the press pulse of each gesture.
module tb_key_click_decoder;

  logic clk = 1'b0;
  logic rst;
  logic key_pulse;
  logic key_level;
  logic single_click;
  logic double_click;
  logic long_press;
  logic busy;

  int vectors     = 0;
  int miscompares = 0;

  key_click_decoder #(
    .DBL_WIN (8),
    .LONG_CNT(20),
    .CNT_W   (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_pulse   (key_pulse),
    .key_level   (key_level),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .busy        (busy)
  );

  // 12 MHz-ish free running clock (period is arbitrary in simulation).
  always #5 clk = ~clk;

  // Inputs are set between edges; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e,
                         input logic es, input logic ed, input logic el, input logic eb);
    chk($sformatf("%s e%0d single_click", tag, e), single_click, es);
    chk($sformatf("%s e%0d double_click", tag, e), double_click, ed);
    chk($sformatf("%s e%0d long_press",   tag, e), long_press,   el);
    chk($sformatf("%s e%0d busy",         tag, e), busy,         eb);
  endtask

  // One gesture. rel1: first release edge; p2: second press edge (-1 none);
  // rel2: second release edge; rst_e: reset edge (-1 none); es/ed/el: edge at
  // which the event is expected after (-1 never); bend: first edge after which
  // busy is low.
  task automatic run(input string tag, input int n, input int rel1, input int p2,
                     input int rel2, input int rst_e, input int es, input int ed,
                     input int el, input int bend);
    for (int e = 0; e < n; e++) begin
      key_pulse = (e == 0) || (e == p2);
      if (e < rel1)
        key_level = 1'b0;
      else if (p2 >= 0 && e >= p2 && (rel2 < 0 || e < rel2))
        key_level = 1'b0;
      else
        key_level = 1'b1;
      rst = (e == rst_e);
      tick();
      chk_all(tag, e, e == es, e == ed, e == el,
              (rst_e >= 0 && e >= rst_e) ? 1'b0 : (e < bend));
    end
    key_pulse = 1'b0;
    key_level = 1'b1;
    rst       = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    key_pulse = 1'b0;
    key_level = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_all(tag, i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_pulse = 1'b0;
    key_level = 1'b1;

    // 1. Reset held 3 cycles with pulses toggling; then a quiet key.
    for (int i = 0; i < 3; i++) begin
      key_pulse = i[0] ? 1'b0 : 1'b1;
      key_level = ~key_pulse;
      tick();
      chk_all("reset", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    idle("idle100", 100);

    // 2. Single click: release at 5, single after 13.
    run("single", 20, 5, -1, -1, -1, 13, -1, -1, 13);
    idle("gap", 3);

    // 3. Double click inside window and on the expiry edge.
    run("dbl10", 22, 5, 10, 14, -1, -1, 10, -1, 14);
    idle("gap", 3);
    run("dbl13", 24, 5, 13, 16, -1, -1, 13, -1, 16);
    idle("gap", 3);

    // 4. Long press held to 40; release coinciding with long expiry.
    run("long", 50, 40, -1, -1, -1, -1, -1, 20, 40);
    idle("gap", 3);
    run("long_rel20", 34, 20, -1, -1, -1, 28, -1, -1, 28);
    idle("gap", 3);

    // 5. Window expires, then a new press at global edge 15 is a fresh gesture.
    run("exp_a", 15, 5, -1, -1, -1, 13, -1, -1, 13);
    run("exp_b", 20, 5, -1, -1, -1, 13, -1, -1, 13);
    idle("gap", 3);

    // 6. Reset at edge 8 during WAIT2 discards the gesture.
    run("rst_mid", 30, 5, -1, -1, 8, -1, -1, -1, 100);
    idle("post_rst", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
